// File: rtl/buzz_arbiter.sv
// buzz_arbiter: quiz round controller. Opens a round on start, grants the
// answer slot to the first fresh press (lowest index wins a tie), runs the
// answer timer, applies the verdict to the winner's saturating score and
// strobes log_en for one cycle with {who, score}.
//
//   state  | meaning
//   IDLE   | waiting for host start; presses and verdicts ignored
//   ARMED  | round open, waiting for the first rising press
//   ANSWER | slot granted to who; waiting for verdict or timer expiry
//   LOG    | one-cycle log strobe; score already updated
module buzz_arbiter #(
  parameter int N_PLAYERS     = 4,
  parameter int SCORE_W       = 8,
  parameter int ANSWER_CYCLES = 1000,
  parameter int PTS_RIGHT     = 10,
  parameter int PTS_WRONG     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_PLAYERS-1:0] buzz,
  input  logic                 judge_ok,
  input  logic                 judge_bad,
  output logic [3:0]           who,
  output logic [SCORE_W-1:0]   score,
  output logic                 log_en,
  output logic                 armed,
  output logic                 timeout
);

  localparam int TW = (ANSWER_CYCLES > 1) ? $clog2(ANSWER_CYCLES) : 1;
  localparam logic [TW-1:0]    TIMER_LOAD = TW'(ANSWER_CYCLES - 1);
  localparam logic [SCORE_W:0] SCORE_MAX  = {1'b0, {SCORE_W{1'b1}}};
  localparam logic [SCORE_W:0] ADD_PTS    = (SCORE_W + 1)'(PTS_RIGHT);
  localparam logic [SCORE_W:0] SUB_PTS    = (SCORE_W + 1)'(PTS_WRONG);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_ANSWER = 2'd2,
    S_LOG    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [N_PLAYERS-1:0] prev_q;
  logic [3:0]           who_q, who_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 timeout_q, timeout_d;
  logic [SCORE_W-1:0]   scores_q [N_PLAYERS];

  logic [N_PLAYERS-1:0] press;
  logic [SCORE_W-1:0]   cur_score;
  logic [SCORE_W:0]     sum_up;
  logic [SCORE_W-1:0]   right_val;
  logic [SCORE_W-1:0]   wrong_val;
  logic                 upd_en;
  logic [SCORE_W-1:0]   upd_val;

  assign press = buzz & ~prev_q;

  // Select the granted player's score; zero when nobody holds the slot.
  always_comb begin
    cur_score = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (who_q == 4'(i + 1)) cur_score = scores_q[i];
    end
  end

  // Saturating score updates, computed one bit wider and then clamped.
  always_comb begin
    sum_up    = {1'b0, cur_score} + ADD_PTS;
    right_val = (sum_up > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : sum_up[SCORE_W-1:0];
    if ({1'b0, cur_score} < SUB_PTS) begin
      wrong_val = '0;
    end else begin
      wrong_val = cur_score - SUB_PTS[SCORE_W-1:0];
    end
  end

  // Next-state, grant, timer and score-update decisions.
  always_comb begin
    state_d   = state_q;
    who_d     = who_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;
    upd_en    = 1'b0;
    upd_val   = cur_score;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          who_d   = '0;
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (|press) begin
          // Scan downward so the lowest pressing index is the last write.
          for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (press[i]) who_d = 4'(i + 1);
          end
          timer_d = TIMER_LOAD;
          state_d = S_ANSWER;
        end
      end
      S_ANSWER: begin
        if (judge_ok) begin
          upd_en  = 1'b1;
          upd_val = right_val;
          state_d = S_LOG;
        end else if (judge_bad) begin
          upd_en  = 1'b1;
          upd_val = wrong_val;
          state_d = S_LOG;
        end else if (timer_q == '0) begin
          upd_en    = 1'b1;
          upd_val   = wrong_val;
          timeout_d = 1'b1;
          state_d   = S_LOG;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_LOG: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control registers and the buzz history used for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      prev_q    <= '0;
      who_q     <= '0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= buzz;
      who_q     <= who_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end

  // Per-player scores; only the granted player's entry is ever written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_PLAYERS; i++) scores_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_PLAYERS; i++) begin
        if (upd_en && (who_q == 4'(i + 1))) scores_q[i] <= upd_val;
      end
    end
  end

  assign who     = who_q;
  assign score   = cur_score;
  assign log_en  = (state_q == S_LOG);
  assign armed   = (state_q == S_ARMED);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_buzz_arbiter.sv
// Bench for buzz_arbiter: directed scenarios plus randomized rounds. The
// driver predicts each round's log record from a plain score table and
// queues it; a negedge monitor pops and compares whenever log_en fires.
module tb_buzz_arbiter;

  localparam int NP = 4;
  localparam int AC = 8;
  localparam int PR = 10;
  localparam int PW = 5;
  localparam int SMAX = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [NP-1:0] buzz = '0;
  logic          judge_ok = 1'b0;
  logic          judge_bad = 1'b0;
  logic [3:0]    who;
  logic [7:0]    score;
  logic          log_en;
  logic          armed;
  logic          timeout;

  buzz_arbiter #(
    .N_PLAYERS(NP), .SCORE_W(8), .ANSWER_CYCLES(AC),
    .PTS_RIGHT(PR), .PTS_WRONG(PW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .buzz(buzz),
    .judge_ok(judge_ok), .judge_bad(judge_bad),
    .who(who), .score(score), .log_en(log_en), .armed(armed), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int who;
    int score;
    int to;
    int cyc;
  } rec_t;

  rec_t q[$];
  int   model_score [NP];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_who = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every log strobe must match the oldest prediction.
  always @(negedge clk) begin
    if (!rst) begin
      if (log_en) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_log: got who=%0d score=%0d with nothing expected", who, score);
        end else begin
          rec_t e;
          e = q.pop_front();
          chk("log_who", int'(who), e.who);
          chk("log_score", int'(score), e.score);
          chk("log_timeout", int'(timeout), e.to);
          chk("log_cycle", cyc, e.cyc);
        end
      end else if (timeout) begin
        tests++;
        fails++;
        $display("FAIL stray_timeout: got timeout=1 expected 0 outside log");
      end
    end
  end

  function automatic int lowest(input logic [NP-1:0] v);
    for (int i = 0; i < NP; i++) if (v[i]) return i + 1;
    return 0;
  endfunction

  // One full round. held: buttons already down before start; pat: buttons
  // that go down while ARMED; d: verdict in ANSWER cycle d (1..AC), or >AC
  // for no verdict; kind: 0 ok, 1 bad, 2 both.
  task automatic round(input logic [NP-1:0] held, input logic [NP-1:0] pat,
                       input int d, input int kind);
    int g, w, n, ns;
    rec_t e;
    buzz = held;
    tick();
    chk("idle_who_hold", int'(who), last_who);
    chk("idle_not_armed", int'(armed), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("armed_after_start", int'(armed), 1);
    chk("who_cleared", int'(who), 0);
    buzz = held | pat;
    w = lowest(pat & ~held);
    tick();
    g = cyc;
    chk("grant_who", int'(who), w);
    chk("armed_fall", int'(armed), 0);
    ns = model_score[w-1];
    if (d <= AC && kind != 1) ns = (ns + PR > SMAX) ? SMAX : ns + PR;
    else ns = (ns - PW < 0) ? 0 : ns - PW;
    model_score[w-1] = ns;
    n = (d <= AC) ? d : AC;
    e.who = w; e.score = ns; e.to = (d > AC) ? 1 : 0; e.cyc = g + n;
    q.push_back(e);
    for (int k = 1; k <= n; k++) begin
      if (k == d) begin
        judge_ok  = (kind != 1);
        judge_bad = (kind != 0);
      end
      buzz  = NP'($urandom);
      start = 1'($urandom_range(0, 1));
      tick();
      judge_ok = 1'b0; judge_bad = 1'b0; start = 1'b0;
    end
    buzz = '0;
    last_who = w;
    tick();
    chk("after_log_idle", int'(log_en), 0);
    tick();
  endtask

  initial begin
    logic [NP-1:0] h, p;
    for (int i = 0; i < NP; i++) model_score[i] = 0;
    #3;
    chk("rst_who", int'(who), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_log_en", int'(log_en), 0);
    chk("rst_armed", int'(armed), 0);
    chk("rst_timeout", int'(timeout), 0);
    tick();
    rst = 1'b0;
    // presses and verdicts in IDLE after reset do nothing
    buzz = 4'b0101; judge_ok = 1'b1;
    tick();
    buzz = '0; judge_ok = 1'b0;
    tick();
    chk("idle_press_who", int'(who), 0);
    chk("idle_press_armed", int'(armed), 0);

    round(4'b0000, 4'b0100, 3, 0);       // basic: player 3 -> 10
    round(4'b0000, 4'b1010, 2, 1);       // tie -> player 2, floors at 0
    round(4'b0000, 4'b0001, AC + 1, 0);  // timeout, player 1 stays 0
    round(4'b0001, 4'b1000, 4, 0);       // held button loses to player 4
    round(4'b0000, 4'b0001, AC, 0);      // verdict in last cycle beats timeout
    for (int r = 0; r < 26; r++) round(4'b0000, 4'b0010, 1 + (r % AC), 0);
    round(4'b0000, 4'b0010, 2, 2);       // both verdicts count as correct, at 255
    round(4'b0000, 4'b0010, AC + 1, 0);  // 255 -> 250

    // reset in the middle of an answer
    buzz = '0; tick();
    start = 1'b1; tick(); start = 1'b0;
    buzz = 4'b0100; tick();
    chk("pre_rst_who", int'(who), 3);
    buzz = '0; tick(); tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_who", int'(who), 0);
    chk("mid_rst_score", int'(score), 0);
    chk("mid_rst_log_en", int'(log_en), 0);
    chk("mid_rst_armed", int'(armed), 0);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < NP; i++) model_score[i] = 0;
    last_who = 0;
    tick();
    round(4'b0000, 4'b0010, 1, 1);       // player 2 score cleared -> stays 0
    round(4'b0000, 4'b0100, 5, 0);       // player 3 back to 10

    for (int r = 0; r < 60; r++) begin
      h = ($urandom_range(0, 2) == 0) ? NP'($urandom_range(0, 7)) : '0;
      do p = NP'($urandom_range(1, 15)); while ((p & ~h) == 0);
      round(h, p, $urandom_range(1, AC + 1), $urandom_range(0, 2));
    end

    tick(); tick();
    chk("pending_logs", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/buzz_arbiter.md
# buzz_arbiter

Round controller and first-press arbiter for the quiz responder. It opens a round on the host's start pulse and grants the answer slot to the first contestant to press. It runs the answer timer, applies the host's verdict to that contestant's saturating score, and emits a one-cycle `log_en` strobe with `{who, score}` for the result-record store.

## Interface

Parameters:
- `N_PLAYERS`, 4: number of contestants (1..15; `who` encodes 1..N, 0 = none).
- `SCORE_W`, 8: score register width.
- `ANSWER_CYCLES`, 1000: maximum clock cycles allowed for an answer (≥1).
- `PTS_RIGHT`, 10: points added on a correct verdict.
- `PTS_WRONG`, 5: points deducted on a wrong verdict or timeout.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  host pulse; opens a round.
- `buzz`  in  N_PLAYERS  contestant buttons, already synchronous to `clk`; bit i = player i+1.
- `judge_ok`  in  1  host verdict: correct.
- `judge_bad`  in  1  host verdict: wrong.
- `who`  out  4  granted player (1..N); 0 = none.
- `score`  out  SCORE_W  current score of player `who`; 0 when `who`=0.
- `log_en`  out  1  one-cycle strobe; `{who, score}` is valid for logging.
- `armed`  out  1  high while in ARMED.
- `timeout`  out  1  one-cycle pulse when the answer timer expires.

## Operation

- Reset values:
  - State is IDLE.
  - `who`=0, `score`=0, `log_en`=0, `armed`=0, `timeout`=0.
  - All per-player scores are 0, the timer is 0, and the buzz history register is 0.
- Edge detection: `prev` registers `buzz` every cycle in every state. A press is `buzz & ~prev`. A button held since before the round opened never wins; the contestant must release and press again.
- FSM states: IDLE, ARMED, ANSWER, LOG.
- IDLE:
  - `start` clears `who` to 0 and moves to ARMED.
  - Presses and verdicts are ignored.
- ARMED:
  - `armed`=1.
  - On the first cycle with any press, grant the lowest-index pressing player (fixed priority on a tie).
  - On grant, set `who`=index+1, load the timer with ANSWER_CYCLES-1, and move to ANSWER.
  - `start` is ignored.
- ANSWER: evaluate in this order each cycle.
  - `judge_ok`: the score becomes min(score+PTS_RIGHT, 2^SCORE_W-1). Move to LOG.
  - Otherwise `judge_bad`: the score becomes max(score-PTS_WRONG, 0). Move to LOG.
  - Otherwise, if timer==0: apply the wrong-verdict update, pulse `timeout`, and move to LOG.
  - Otherwise decrement the timer.
  - `judge_ok` and `judge_bad` asserted together count as correct.
  - Presses by any player, including the granted one, are ignored. `start` is ignored.
- LOG:
  - Lasts exactly one cycle with `log_en`=1.
  - `who` holds and `score` already reflects the update.
  - Next state is IDLE.
- `who` and `score` hold after LOG until the next `start`.
- Score arithmetic is done at SCORE_W+1 bits, then clamped. Scores persist across rounds; only `rst` clears them.

## Timing

- Press visible at cycle t (`buzz` high at t, low at t-1) while ARMED:
  - `who` and ANSWER are valid from t+1.
  - `armed` falls at t+1.
- `start` at cycle t in IDLE: `armed`=1 from t+1. A press at t+1 is accepted.
- Verdict sampled at cycle k in ANSWER: LOG at k+1 with `log_en`=1 and the updated `score`, then IDLE at k+2.
- With no verdict, ANSWER lasts exactly ANSWER_CYCLES cycles:
  - `timeout` and the state change to LOG both occur on the edge that ends the last ANSWER cycle, so `timeout` is high in the first LOG cycle alongside `log_en`.
  - A verdict in the last ANSWER cycle beats the timeout.
- `rst` mid-round aborts immediately: reset values apply asynchronously and no `log_en` is issued.
- Round turnaround, grant to log: minimum 2 cycles, maximum ANSWER_CYCLES+1.

## Test plan

Parameters for all scenarios: N_PLAYERS=4, SCORE_W=8, ANSWER_CYCLES=8, PTS_RIGHT=10, PTS_WRONG=5.

1. Basic round: `start`; press `buzz`[2] (player 3); `judge_ok` 3 cycles later -> `who`=3 one cycle after the press; one `log_en` with `who`=3, `score`=10; then IDLE.
2. Simultaneous press: `buzz`=4'b1010 rises in one cycle while ARMED -> `who`=2. Player 4's later `judge_bad`-free presses change nothing.
3. Timeout and floor: player 1 at 0 points; no verdict -> `timeout`=1 and `log_en`=1 in the same cycle, exactly 8 cycles after grant; `score`=0 (saturated).
4. Held button and pre-start press: player 1 holds `buzz`[0] through `start`, player 4 presses after `start` -> `who`=4. Presses during IDLE leave `who`=0.
5. Saturation: player 2 is granted and gets `judge_ok` 26 times across rounds -> `score` reaches 255 and stays there. Both verdicts asserted together -> counted as correct.
6. Reset mid-ANSWER: assert `rst` with `who`=3 -> all outputs and scores are 0 immediately, no `log_en`. After release, `start` works normally.
